seq_muldiv_ctrl: RTL and testbench
==================================

Name: seq_muldiv_ctrl

Overview:
Multi-cycle 16-bit multiply/divide sequencer for the single-cycle processor's MUL/DIV instructions; the processor stalls on busy.
Drives the operand inputs of the 16-bit CLA add/sub stage every cycle and consumes its sum and carry-out. It iterates shift-add for multiply and restoring subtract for divide.
Returns a 32-bit result as hi:lo with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand width; the datapath is fixed to WIDTH and the iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
op  in  2  op[0]: 0=MUL, 1=DIV; op[1]: signed (honoured only with SIGNED_MULDIV_EN)
opa  in  WIDTH  multiplicand / dividend, sampled on accepted start
opb  in  WIDTH  multiplier / divisor, sampled on accepted start
add_a  out  WIDTH  to add/sub stage A
add_b  out  WIDTH  to add/sub stage B
add_sub  out  1  to add/sub stage subtract select
add_cin  out  1  to add/sub stage carry-in; tied 0
add_s  in  WIDTH  sum from add/sub stage (same-cycle combinational)
add_cout  in  1  carry-out; for subtract it is the carry of A+~B+1 (1 = no borrow)
busy  out  1  iteration in progress
done  out  1  one-cycle pulse; results valid from this cycle
result_lo  out  WIDTH  product[15:0] / quotient
result_hi  out  WIDTH  product[31:16] / remainder
div_by_zero  out  1  set with done when DIV and opb==0

Behaviour:
- Reset (async, any state): FSM=IDLE; busy, done, div_by_zero, result_lo, result_hi, counter and all internal registers cleared to 0.
- FSM states: IDLE -> RUN -> DONE -> IDLE. DIV with opb==0 goes IDLE -> DONE directly. The signed build inserts PRE before RUN and POST after RUN.
- Start handling:
  - start is accepted in IDLE or DONE; start while busy=1 is ignored.
  - Accepted start at edge T: RUN occupies T+1..T+16 (counter 0..15, busy=1), done=1 at T+17 with busy=0.
  - result_* update at T+17 and hold until the next accepted start completes.
- MUL (unsigned), registers hi=0, lo=opb, m=opa. Each RUN cycle:
  - add_a=hi, add_b=lo[0]?m:0, add_sub=0.
  - hi <= {add_cout, add_s[15:1]}; lo <= {add_s[0], lo[15:1]}.
  - After 16 cycles, result_hi=hi, result_lo=lo.
- DIV (unsigned), registers hi=0, lo=opa, d=opb. Each RUN cycle:
  - p={hi[14:0], lo[15]}; add_a=p, add_b=d, add_sub=1.
  - q=hi[15] | add_cout; hi <= q ? add_s : p; lo <= {lo[14:0], q}.
  - Final: quotient=lo, remainder=hi.
- Divide by zero: done at T+1, result_lo=16'hFFFF, result_hi=opa, div_by_zero=1; no RUN cycles.
- div_by_zero clears on the next accepted start.
- Outside RUN, add_a, add_b and add_sub are driven 0.
- op changing during RUN has no effect; operands are captured only at accept.
- start coincident with done is accepted; done still pulses for one cycle only.

Optional Feature:
- Macro SIGNED_MULDIV_EN.
- Defined, op[1]=1 selects signed operation:
  - PRE (1 cycle) takes absolute values of the operands with a local incrementer; POST (1 cycle) applies signs. Latency becomes T+19.
  - Product sign = sa^sb.
  - Quotient sign = sa^sb; remainder sign = sign of dividend.
  - -32768 / -1 returns q=16'h8000, r=0, no flag.
  - Divide by zero behaves as in the unsigned case.
- Undefined: op[1] is ignored, all operations are unsigned, and PRE/POST do not exist.

Decomposition:
- Package muldiv_pkg holds:
  - state enum (IDLE, PRE, RUN, POST, DONE);
  - op encodings OP_MUL=0, OP_DIV=1, OP_SIGNED_BIT=1;
  - constants ITER=16 and DIV0_QUOT=16'hFFFF.
- One natural sub-module, muldiv_fsm: state register, iteration counter, busy/done generation.
- Datapath shift registers stay in the top module.

Test Plan:
- MUL 0x1234 * 0x5678 with the bench-modelled add/sub stage -> done at T+17, hi:lo = 0x0626:0x0060, busy high exactly 16 cycles.
- MUL 0xFFFF * 0xFFFF -> 0xFFFE:0x0001.
- MUL 0x0000 * 0xABCD -> 0x0000:0x0000.
- DIV 1000 / 7 -> q=0x008E, r=0x0006.
- DIV 0xFFFF / 0x0001 -> q=0xFFFF, r=0x0000.
- DIV 0x1234 / 0 -> done at T+1, q=0xFFFF, r=0x1234, div_by_zero=1; the next valid DIV clears the flag.
- Start during busy ignored; rst_n low at iteration 8 -> all outputs 0 immediately.
- After release, MUL 3*5 -> 0x0000:0x000F.
- With SIGNED_MULDIV_EN: -7 * 3 -> 0xFFFF:0xFFEB at T+19.
- With SIGNED_MULDIV_EN: -7 / 2 -> q=0xFFFD, r=0xFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide controller.
package muldiv_pkg;

  localparam int          ITER          = 16;
  localparam logic [15:0] DIV0_QUOT     = 16'hFFFF;
  localparam logic        OP_MUL        = 1'b0;
  localparam logic        OP_DIV        = 1'b1;
  localparam int          OP_SIGNED_BIT = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    RUN  = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [15:0] neg16(input logic [15:0] x);
    return ~x + 16'd1;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer control: state register, iteration counter, busy/done generation.
// sgn_start selects the PRE/POST path for a newly accepted op, sgn_run for the op in flight.
module muldiv_fsm
  import muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       div0,
  input  logic       sgn_start,
  input  logic       sgn_run,
  output logic       accept,
  output logic       busy,
  output logic       done,
  output logic       in_pre,
  output logic       in_run,
  output logic       in_post,
  output logic       last_iter
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          cnt_d   = '0;
          state_d = div0 ? DONE : (sgn_start ? PRE : RUN);
        end
      end
      PRE:  state_d = RUN;
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = sgn_run ? POST : DONE;
      end
      POST:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = start && ((state_q == IDLE) || (state_q == DONE));
    in_pre    = (state_q == PRE);
    in_run    = (state_q == RUN);
    in_post   = (state_q == POST);
    busy      = in_pre || in_run || in_post;
    done      = (state_q == DONE);
    last_iter = in_run && (cnt_q == 4'(ITER - 1));
  end

endmodule

// File: rtl/seq_muldiv_ctrl.sv
// Multi-cycle 16-bit MUL/DIV sequencer driving an external CLA add/sub stage.
// Define SIGNED_MULDIV_EN to honour op[1] (signed ops via PRE/POST sign fix-up).
module seq_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  logic             accept, in_pre, in_run, in_post, last_iter;
  logic             op_sgn, div0;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             div_q, div_d, sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] shl_p;
  logic             qbit;
  logic [31:0]      prod;

`ifdef SIGNED_MULDIV_EN
  assign op_sgn = op[OP_SIGNED_BIT];
`else
  logic unused_op_sgn;
  assign op_sgn        = 1'b0;
  assign unused_op_sgn = op[OP_SIGNED_BIT];
`endif

  assign div0 = (op[0] == OP_DIV) && (opb == '0);

  muldiv_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .div0      (div0),
    .sgn_start (op_sgn),
    .sgn_run   (sgn_q),
    .accept    (accept),
    .busy      (busy),
    .done      (done),
    .in_pre    (in_pre),
    .in_run    (in_run),
    .in_post   (in_post),
    .last_iter (last_iter)
  );

  // Add/sub stage operands: shift-add for MUL, trial subtract for DIV.
  always_comb begin
    shl_p   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (in_run) begin
      if (div_q) begin
        add_a   = shl_p;
        add_b   = m_q;
        add_sub = 1'b1;
      end else begin
        add_a = hi_q;
        add_b = lo_q[0] ? m_q : '0;
      end
    end
  end

  assign add_cin = 1'b0;

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    div_d    = div_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dbz_d    = dbz_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    qbit     = hi_q[WIDTH-1] | add_cout;
    prod     = {hi_q, lo_q};

    if (accept) begin
      hi_d  = '0;
      div_d = op[0];
      sgn_d = op_sgn;
      sa_d  = opa[WIDTH-1];
      sb_d  = opb[WIDTH-1];
      dbz_d = div0;
      lo_d  = (op[0] == OP_DIV) ? opa : opb;
      m_d   = (op[0] == OP_DIV) ? opb : opa;
      if (div0) begin
        res_lo_d = DIV0_QUOT;
        res_hi_d = opa;
      end
    end

    // Each shift register takes its own magnitude; its MSB is that operand's sign.
    if (in_pre) begin
      lo_d = lo_q[WIDTH-1] ? neg16(lo_q) : lo_q;
      m_d  = m_q[WIDTH-1]  ? neg16(m_q)  : m_q;
    end

    if (in_run) begin
      if (div_q) begin
        hi_d = qbit ? add_s : shl_p;
        lo_d = {lo_q[WIDTH-2:0], qbit};
      end else begin
        hi_d = {add_cout, add_s[WIDTH-1:1]};
        lo_d = {add_s[0], lo_q[WIDTH-1:1]};
      end
      if (last_iter && !sgn_q) begin
        res_hi_d = hi_d;
        res_lo_d = lo_d;
      end
    end

    if (in_post) begin
      if (div_q) begin
        res_lo_d = (sa_q ^ sb_q) ? neg16(lo_q) : lo_q;
        res_hi_d = sa_q ? neg16(hi_q) : hi_q;
      end else begin
        if (sa_q ^ sb_q) prod = neg32(prod);
        res_hi_d = prod[31:16];
        res_lo_d = prod[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      div_q    <= 1'b0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dbz_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      div_q    <= div_d;
      sgn_q    <= sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dbz_q    <= dbz_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_muldiv_ctrl.sv
// Scoreboard bench for seq_muldiv_ctrl with a behavioural 16-bit add/sub stage.
module tb_seq_muldiv_ctrl;

`ifdef SIGNED_MULDIV_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_i = '0;
  logic [15:0] opa_i = '0, opb_i = '0;
  logic [15:0] add_a, add_b, add_s;
  logic        add_sub, add_cin, add_cout;
  logic        busy, done, div_by_zero;
  logic [15:0] result_lo, result_hi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign {add_cout, add_s} = add_sub ? ({1'b0, add_a} + {1'b0, ~add_b} + 17'd1)
                                     : ({1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin});

  seq_muldiv_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op_i),
    .opa         (opa_i),
    .opb         (opb_i),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sub     (add_sub),
    .add_cin     (add_cin),
    .add_s       (add_s),
    .add_cout    (add_cout),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic        sgn;
    logic [31:0] p;
    int          q, r;
    sgn   = SGN_EN && o[1];
    e.dbz = 1'b0;
    if (o[0] == 1'b0) begin
      e.lat = sgn ? 19 : 17;
      if (sgn) p = 32'(int'($signed(a)) * int'($signed(b)));
      else     p = {16'd0, a} * {16'd0, b};
      e.hi = p[31:16];
      e.lo = p[15:0];
    end else if (b == 16'd0) begin
      e.lat = 1;
      e.lo  = 16'hFFFF;
      e.hi  = a;
      e.dbz = 1'b1;
    end else if (sgn) begin
      e.lat = 19;
      q     = int'($signed(a)) / int'($signed(b));
      r     = int'($signed(a)) % int'($signed(b));
      e.lo  = q[15:0];
      e.hi  = r[15:0];
    end else begin
      e.lat = 17;
      e.lo  = a / b;
      e.hi  = a % b;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input bit poke);
    exp_t e;
    int   n, nbusy;
    bit   seen;
    exp_q.push_back(model(o, a, b));
    op_i  = o;
    opa_i = a;
    opb_i = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i  = 2'($urandom);
    opa_i = 16'($urandom);
    opb_i = 16'($urandom);
    n = 0;
    nbusy = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) seen = 1'b1;
      else begin
        if (busy) nbusy++;
        if (poke && n == 5) start = 1'b1;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_busy_cycles"}, nbusy, e.lat - 1);
      chk({tag, "_lo"}, {16'd0, result_lo}, {16'd0, e.lo});
      chk({tag, "_hi"}, {16'd0, result_hi}, {16'd0, e.hi});
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_add_idle"}, {add_a, add_b}, 32'd0);
    chk({tag, "_sub_cin_idle"}, {30'd0, add_sub, add_cin}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, done, div_by_zero, 13'd0, result_hi | result_lo}, 32'd0);
    rst_n = 1'b1;
    idle_chk("post_reset");

    run_op("mul_1234_5678", 2'b00, 16'h1234, 16'h5678, 1'b0);
    idle_chk("mul_1234_5678");
    run_op("mul_ffff_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("mul_0_abcd", 2'b00, 16'h0000, 16'hABCD, 1'b0);
    run_op("div_1000_7", 2'b01, 16'd1000, 16'd7, 1'b0);
    run_op("div_by_zero", 2'b01, 16'h1234, 16'h0000, 1'b0);
    run_op("div_clears_flag", 2'b01, 16'd1000, 16'd7, 1'b0);
    run_op("div_ffff_1", 2'b01, 16'hFFFF, 16'h0001, 1'b0);
    idle_chk("div_ffff_1");
    run_op("busy_ignore", 2'b00, 16'd3, 16'd5, 1'b1);
    idle_chk("busy_ignore");

    // Reset in the middle of an iteration.
    op_i  = 2'b00;
    opa_i = 16'h00FF;
    opb_i = 16'h0101;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ctrl", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("midrun_rst_result", {result_hi, result_lo}, 32'd0);
    chk("midrun_rst_add", {add_a, add_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_3_5", 2'b00, 16'd3, 16'd5, 1'b0);
    run_op("smul_m7_3", 2'b10, 16'hFFF9, 16'd3, 1'b0);
    run_op("sdiv_m7_2", 2'b11, 16'hFFF9, 16'd2, 1'b0);
    run_op("sdiv_min_m1", 2'b11, 16'h8000, 16'hFFFF, 1'b0);
    run_op("sdiv_by_zero", 2'b11, 16'h8001, 16'h0000, 1'b0);
    idle_chk("final");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
